// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types and helpers for the round-robin grant arbiter and its
// priority encoders.
package rr_grant_arbiter_pkg;

    // Arbitration policy selected by ARB_ROUND_ROBIN.
    typedef enum logic [0:0] {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Hold policy selected by ARB_BLOCK / ARB_BLOCK_ACK.
    typedef enum logic [1:0] {
        HOLD_NONE  = 2'd0,
        HOLD_LEVEL = 2'd1,
        HOLD_ACK   = 2'd2
    } hold_mode_e;

    // Width of an index into a vector of 'ports' entries, never below 1 bit.
    function automatic int idx_width(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

    // Decode the hold policy from the two blocking parameters.
    function automatic hold_mode_e hold_mode(input int arb_block, input int arb_block_ack);
        if (arb_block == 0) begin
            return HOLD_NONE;
        end
        return (arb_block_ack != 0) ? HOLD_ACK : HOLD_LEVEL;
    endfunction

endpackage

// File: rtl/rr_grant_arbiter_priority_encoder.sv
// Combinational priority encoder: picks the highest-priority set bit of
// input_unencoded and reports it both as an index and as a one-hot vector.
module priority_encoder
    import rr_grant_arbiter_pkg::*;
#(
    parameter int WIDTH             = 4,
    parameter int LSB_HIGH_PRIORITY = 0
) (
    input  logic [WIDTH-1:0]              input_unencoded,
    output logic                          output_valid,
    output logic [idx_width(WIDTH)-1:0]   output_encoded,
    output logic [WIDTH-1:0]              output_unencoded
);

    localparam int IW = idx_width(WIDTH);

    // Scan so that the last matching bit visited is the highest-priority one.
    always_comb begin
        output_valid   = 1'b0;
        output_encoded = '0;
        if (LSB_HIGH_PRIORITY != 0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (input_unencoded[i]) begin
                    output_valid   = 1'b1;
                    output_encoded = IW'(i);
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (input_unencoded[i]) begin
                    output_valid   = 1'b1;
                    output_encoded = IW'(i);
                end
            end
        end
    end

    // One-hot view of the winner, all-zero when nothing is requested.
    always_comb begin
        output_unencoded = '0;
        if (output_valid) begin
            output_unencoded = WIDTH'(1) << output_encoded;
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Registered N-way arbiter. Two priority encoders look at the raw request
// vector and at the request vector filtered by a rotation mask; the masked
// result wins when it exists, which gives round-robin fairness. Grants can
// optionally be held until the owner drops its request or acknowledges.
module rr_grant_arbiter
    import rr_grant_arbiter_pkg::*;
#(
    parameter int PORTS             = 4,
    parameter int ARB_ROUND_ROBIN   = 0,
    parameter int ARB_BLOCK         = 0,
    parameter int ARB_BLOCK_ACK     = 1,
    parameter int LSB_HIGH_PRIORITY = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PORTS-1:0]              request,
    input  logic [PORTS-1:0]              acknowledge,
    output logic [PORTS-1:0]              grant,
    output logic                          grant_valid,
    output logic [idx_width(PORTS)-1:0]   grant_encoded
);

    localparam int         IW        = idx_width(PORTS);
    localparam arb_mode_e  ARB_MODE  = (ARB_ROUND_ROBIN != 0) ? ARB_RR : ARB_FIXED;
    localparam hold_mode_e HOLD_MODE = hold_mode(ARB_BLOCK, ARB_BLOCK_ACK);

    // Architectural state.
    logic [PORTS-1:0] grant_reg;
    logic             grant_valid_reg;
    logic [IW-1:0]    grant_encoded_reg;
    logic [PORTS-1:0] mask_reg;

    // Next-state values.
    logic [PORTS-1:0] grant_next;
    logic             grant_valid_next;
    logic [IW-1:0]    grant_encoded_next;
    logic [PORTS-1:0] mask_next;

    // Encoder outputs.
    logic             pe_a_valid;
    logic [IW-1:0]    pe_a_encoded;
    logic [PORTS-1:0] pe_a_unencoded;
    logic             pe_b_valid;
    logic [IW-1:0]    pe_b_encoded;
    logic [PORTS-1:0] pe_b_unencoded;

    // Arbitration result for this cycle.
    logic             win_valid;
    logic [IW-1:0]    win_encoded;
    logic [PORTS-1:0] win_unencoded;
    logic [PORTS-1:0] win_low_mask;
    logic [PORTS-1:0] win_rot_mask;
    logic             hold;

    logic [PORTS-1:0] masked_request;

    assign masked_request = request & mask_reg;

    priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
    ) u_pe_a (
        .input_unencoded  (request),
        .output_valid     (pe_a_valid),
        .output_encoded   (pe_a_encoded),
        .output_unencoded (pe_a_unencoded)
    );

    priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
    ) u_pe_b (
        .input_unencoded  (masked_request),
        .output_valid     (pe_b_valid),
        .output_encoded   (pe_b_encoded),
        .output_unencoded (pe_b_unencoded)
    );

    // Pick the winner: masked encoder first under round-robin, with the
    // unmasked encoder as the wrap-around fallback.
    always_comb begin
        win_valid     = pe_a_valid;
        win_encoded   = pe_a_encoded;
        win_unencoded = pe_a_unencoded;
        if (ARB_MODE == ARB_RR && pe_b_valid) begin
            win_valid     = 1'b1;
            win_encoded   = pe_b_encoded;
            win_unencoded = pe_b_unencoded;
        end
    end

    // Rotation mask for the winner: bits strictly below it (MSB-priority)
    // or strictly above it (LSB-priority) stay eligible next time.
    always_comb begin
        win_low_mask = (win_unencoded << 1) - PORTS'(1);
        win_rot_mask = (LSB_HIGH_PRIORITY != 0) ? ~win_low_mask
                                                : (win_unencoded - PORTS'(1));
    end

    // Decide whether the current owner keeps the grant this cycle.
    always_comb begin
        hold = 1'b0;
        if (grant_valid_reg) begin
            case (HOLD_MODE)
                HOLD_LEVEL: hold = |(request & grant_reg);
                HOLD_ACK:   hold = ~|(acknowledge & grant_reg);
                default:    hold = 1'b0;
            endcase
        end
    end

    // Next grant and mask: keep everything while held, otherwise take the
    // winner; the mask only moves when a new grant is issued.
    always_comb begin
        grant_next         = grant_reg;
        grant_valid_next   = grant_valid_reg;
        grant_encoded_next = grant_encoded_reg;
        mask_next          = mask_reg;
        if (!hold) begin
            grant_next         = win_unencoded;
            grant_valid_next   = win_valid;
            grant_encoded_next = win_valid ? win_encoded : '0;
            if (win_valid) begin
                mask_next = win_rot_mask;
            end
        end
    end

    // State registers; reset clears the grant and reopens the full mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_reg         <= '0;
            grant_valid_reg   <= 1'b0;
            grant_encoded_reg <= '0;
            mask_reg          <= '1;
        end else begin
            grant_reg         <= grant_next;
            grant_valid_reg   <= grant_valid_next;
            grant_encoded_reg <= grant_encoded_next;
            mask_reg          <= mask_next;
        end
    end

    assign grant         = grant_reg;
    assign grant_valid   = grant_valid_reg;
    assign grant_encoded = grant_encoded_reg;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: four configurations side by side
// (fixed priority, round-robin, blocking on acknowledge, blocking on level).
module tb_rr_grant_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic [3:0] req_fix = '0, ack_fix = '0, gnt_fix;
    logic [3:0] req_rr  = '0, ack_rr  = '0, gnt_rr;
    logic [3:0] req_ack = '0, ack_ack = '0, gnt_ack;
    logic [3:0] req_lvl = '0, ack_lvl = '0, gnt_lvl;
    logic       vld_fix, vld_rr, vld_ack, vld_lvl;
    logic [1:0] enc_fix, enc_rr, enc_ack, enc_lvl;

    int tests_run = 0;
    int tests_failed = 0;

    rr_grant_arbiter #(.PORTS(4), .ARB_ROUND_ROBIN(0), .ARB_BLOCK(0),
                       .ARB_BLOCK_ACK(1), .LSB_HIGH_PRIORITY(0)) u_fix (
        .clk(clk), .rst(rst), .request(req_fix), .acknowledge(ack_fix),
        .grant(gnt_fix), .grant_valid(vld_fix), .grant_encoded(enc_fix));

    rr_grant_arbiter #(.PORTS(4), .ARB_ROUND_ROBIN(1), .ARB_BLOCK(0),
                       .ARB_BLOCK_ACK(1), .LSB_HIGH_PRIORITY(1)) u_rr (
        .clk(clk), .rst(rst), .request(req_rr), .acknowledge(ack_rr),
        .grant(gnt_rr), .grant_valid(vld_rr), .grant_encoded(enc_rr));

    rr_grant_arbiter #(.PORTS(4), .ARB_ROUND_ROBIN(1), .ARB_BLOCK(1),
                       .ARB_BLOCK_ACK(1), .LSB_HIGH_PRIORITY(1)) u_ack (
        .clk(clk), .rst(rst), .request(req_ack), .acknowledge(ack_ack),
        .grant(gnt_ack), .grant_valid(vld_ack), .grant_encoded(enc_ack));

    rr_grant_arbiter #(.PORTS(4), .ARB_ROUND_ROBIN(1), .ARB_BLOCK(1),
                       .ARB_BLOCK_ACK(0), .LSB_HIGH_PRIORITY(1)) u_lvl (
        .clk(clk), .rst(rst), .request(req_lvl), .acknowledge(ack_lvl),
        .grant(gnt_lvl), .grant_valid(vld_lvl), .grant_encoded(enc_lvl));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Structural invariants on one instance.
    task automatic check_inv(input string tag, input logic [3:0] g, input logic v, input logic [1:0] e);
        check({tag, "_onehot0"}, 32'($onehot0(g)), 32'd1);
        check({tag, "_valid"}, 32'(v), 32'(|g));
        check({tag, "_enc"}, 32'(g), v ? 32'(4'b0001 << e) : 32'd0);
    endtask

    logic [3:0] rr_seq [5];

    initial begin
        rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
        rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001;

        // Reset wins over requests.
        rst = 1'b1;
        req_fix = 4'b1111; req_rr = 4'b1111; req_ack = 4'b1111; req_lvl = 4'b1111;
        step();
        check("rst_fix_grant", 32'(gnt_fix), 32'd0);
        check("rst_fix_valid", 32'(vld_fix), 32'd0);
        check("rst_fix_enc",   32'(enc_fix), 32'd0);
        check("rst_rr_grant",  32'(gnt_rr),  32'd0);
        check("rst_ack_grant", 32'(gnt_ack), 32'd0);
        check("rst_lvl_grant", 32'(gnt_lvl), 32'd0);

        req_fix = 4'b0000; req_rr = 4'b0000; req_ack = 4'b0000; req_lvl = 4'b0000;
        step();
        rst = 1'b0;

        // Fixed priority, MSB highest.
        req_fix = 4'b0101;
        req_rr  = 4'b1111;
        req_ack = 4'b0010;
        req_lvl = 4'b0001;
        step();
        check("fix_grant",   32'(gnt_fix), 32'b0100);
        check("fix_enc",     32'(enc_fix), 32'd2);
        check("fix_valid",   32'(vld_fix), 32'd1);
        check("rr_seq0",     32'(gnt_rr),  32'(rr_seq[0]));
        check("ack_first",   32'(gnt_ack), 32'b0010);
        check("lvl_first",   32'(gnt_lvl), 32'b0001);

        // Round-robin rotation over a steady full request; other blocks hold.
        req_ack = 4'b1010;
        req_lvl = 4'b0101;
        for (int i = 1; i < 5; i++) begin
            step();
            check($sformatf("rr_seq%0d", i), 32'(gnt_rr), 32'(rr_seq[i]));
            check($sformatf("fix_hold%0d", i), 32'(gnt_fix), 32'b0100);
            check($sformatf("ack_hold%0d", i), 32'(gnt_ack), 32'b0010);
            check($sformatf("lvl_hold%0d", i), 32'(gnt_lvl), 32'b0001);
        end
        check("rr_enc_wrap", 32'(enc_rr), 32'd0);

        // Round-robin wrap: walk to index 3, then only low ports request.
        for (int i = 1; i < 4; i++) begin
            step();
            check($sformatf("rr_walk%0d", i), 32'(gnt_rr), 32'(4'b0001 << i));
        end
        check("rr_enc3", 32'(enc_rr), 32'd3);
        req_rr = 4'b0011;
        req_fix = 4'b0011;
        ack_ack = 4'b0100;
        step();
        check("rr_wrap", 32'(gnt_rr), 32'b0001);
        check("fix_0011", 32'(gnt_fix), 32'b0010);
        check("ack_ignore_other", 32'(gnt_ack), 32'b0010);
        check("lvl_hold_level", 32'(gnt_lvl), 32'b0001);

        // Acknowledge the owner while port 3 also requests.
        ack_ack = 4'b0010;
        req_lvl = 4'b0100;
        req_fix = 4'b0000;
        step();
        check("ack_release", 32'(gnt_ack), 32'b1000);
        check("ack_enc",     32'(enc_ack), 32'd3);
        check("lvl_release", 32'(gnt_lvl), 32'b0100);
        check("fix_idle",    32'(gnt_fix), 32'd0);
        check("fix_idle_v",  32'(vld_fix), 32'd0);
        check("fix_idle_e",  32'(enc_fix), 32'd0);

        // Withdrawn request is still held until acknowledged.
        ack_ack = 4'b0000;
        req_ack = 4'b0000;
        step();
        check("ack_withdrawn_hold", 32'(gnt_ack), 32'b1000);
        check("lvl_still", 32'(gnt_lvl), 32'b0100);
        ack_ack = 4'b1000;
        step();
        check("ack_idle",   32'(gnt_ack), 32'd0);
        check("ack_idle_v", 32'(vld_ack), 32'd0);
        ack_ack = 4'b0000;

        // Reset mid-hold: grant drops and the rotation mask reopens.
        req_lvl = 4'b0001;
        step();
        step();
        check("lvl_own0", 32'(gnt_lvl), 32'b0001);
        rst = 1'b1;
        step();
        check("lvl_rst_hold", 32'(gnt_lvl), 32'd0);
        check("lvl_rst_valid", 32'(vld_lvl), 32'd0);
        rst = 1'b0;
        req_lvl = 4'b0011;
        step();
        check("lvl_mask_reset", 32'(gnt_lvl), 32'b0001);

        // Random stimulus with structural invariants on every instance.
        for (int c = 0; c < 200; c++) begin
            req_fix = 4'($urandom); req_rr = 4'($urandom);
            req_ack = 4'($urandom); req_lvl = 4'($urandom);
            ack_ack = 4'($urandom); ack_lvl = 4'($urandom);
            step();
            check_inv("fix", gnt_fix, vld_fix, enc_fix);
            check_inv("rr",  gnt_rr,  vld_rr,  enc_rr);
            check_inv("ack", gnt_ack, vld_ack, enc_ack);
            check_inv("lvl", gnt_lvl, vld_lvl, enc_lvl);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
